// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and opcode values for the wait-state control sequencer
// Contents:
//   state_t          - sequencer states, one per microcycle of the instruction flow
//   LOAD .. HALT     - opcode values decoded from the IR opcode field
//   is_mem_state()   - true for the states that hold a memory cycle open (CS high)
package seq_pkg;

    typedef enum logic [3:0] {
        S_FETCH_A,
        S_FETCH_R,
        S_FETCH_I,
        S_DECODE,
        S_ST_M,
        S_ST_W,
        S_EX_R,
        S_LD_A,
        S_ALU_X,
        S_BRANCH,
        S_HALT
    } state_t;

    localparam int LOAD  = 0;
    localparam int STORE = 1;
    localparam int ADD   = 2;
    localparam int SUB   = 3;
    localparam int BNE   = 4;
    localparam int BEQ   = 5;
    localparam int JMP   = 6;
    localparam int AND   = 7;
    localparam int NOP   = 8;
    localparam int HALT  = 15;

    function automatic logic is_mem_state(state_t s);
        return s inside {S_FETCH_R, S_EX_R, S_ST_W};
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory wait cycles and flags when the wait limit is hit
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-high reset, clears the counter
//   waiting   in   sequencer is in a memory state (CS cycle open)
//   mem_ready in   memory completes the current cycle at this edge
//   expired   out  limit reached while memory is still not ready (combinational)
module mem_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    output logic expired
);

    logic [WAIT_W-1:0] count;
    logic              stalled;

    assign stalled = waiting && !mem_ready;
    // A ready on the limit cycle completes the transfer, so expiry needs !mem_ready.
    assign expired = stalled && (count == WAIT_W'(MAX_WAIT));

    // Counter only runs while stalled; any completion or non-memory state clears it,
    // and an expiry sends the sequencer to HALT so the count restarts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= (stalled && !expired) ? count + 1'b1 : '0;
    end

endmodule

// File: rtl/sequencer_wait.sv
// sequencer_wait: microcoded accumulator-CPU control sequencer with memory wait-state handshake
// Optional feature macro: SEQ_MEM_TIMEOUT_EN (memory wait timeout -> HALT with sticky bus_error)
// Ports:
//   clock, reset           system clock (rising edge), asynchronous active-high reset
//   z_flag                 accumulator-zero flag, sampled only in DECODE
//   op[OP_W-1:0]           opcode from IR, stable from FETCH_I onward
//   mem_ready              memory completes the current CS cycle at this edge
//   ACC_bus .. load_MDR    datapath bus-drive and register-load strobes
//   ALU_ACC .. ALU_and     ALU input select and operation select
//   INC_PC, Addr_bus       PC increment, IR address onto the bus
//   CS, R_NW               memory select, read/not-write
//   halted                 high in the HALT state
//   bus_error              sticky memory-timeout flag (always 0 without the macro)
// All outputs decode the present state and are forced low while reset is high.
module sequencer_wait
    import seq_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            z_flag,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            load_IR,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            ALU_and,
    output logic            INC_PC,
    output logic            Addr_bus,
    output logic            CS,
    output logic            R_NW,
    output logic            halted,
    output logic            bus_error
);

    state_t state;
    logic   op_load, op_store, op_add, op_sub, op_bne, op_beq, op_jmp, op_and, op_nop, op_halt;
    logic   needs_operand;
    logic   timeout;

    assign op_load  = op == OP_W'(LOAD);
    assign op_store = op == OP_W'(STORE);
    assign op_add   = op == OP_W'(ADD);
    assign op_sub   = op == OP_W'(SUB);
    assign op_bne   = op == OP_W'(BNE);
    assign op_beq   = op == OP_W'(BEQ);
    assign op_jmp   = op == OP_W'(JMP);
    assign op_and   = op == OP_W'(AND);
    assign op_nop   = op == OP_W'(NOP);
    assign op_halt  = op == OP_W'(HALT);

    // Operand read is needed for data ops and for branches whose condition holds;
    // a failing branch condition skips the memory cycle entirely.
    assign needs_operand = op_load || op_add || op_sub || op_and ||
                           (op_bne && !z_flag) || (op_beq && z_flag);

`ifdef SEQ_MEM_TIMEOUT_EN
    logic err;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .waiting   (is_mem_state(state)),
        .mem_ready (mem_ready),
        .expired   (timeout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (timeout)
            err <= 1'b1;
    end

    assign bus_error = !reset && err;
`else
    logic unused_cfg;

    assign unused_cfg = ^{MAX_WAIT, WAIT_W};
    assign timeout    = 1'b0;
    assign bus_error  = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_FETCH_A;
        else if (timeout)
            state <= S_HALT;
        else begin
            case (state)
                S_FETCH_A: state <= S_FETCH_R;
                S_FETCH_R: state <= mem_ready ? S_FETCH_I : S_FETCH_R;
                S_FETCH_I: state <= S_DECODE;
                S_DECODE:  state <= op_store      ? S_ST_M :
                                    needs_operand ? S_EX_R :
                                    op_halt       ? S_HALT : S_FETCH_A;
                S_ST_M:    state <= S_ST_W;
                S_ST_W:    state <= mem_ready ? S_FETCH_A : S_ST_W;
                S_EX_R:    state <= !mem_ready          ? S_EX_R :
                                    op_load             ? S_LD_A :
                                    (op_bne || op_beq)  ? S_BRANCH : S_ALU_X;
                S_LD_A:    state <= S_FETCH_A;
                S_ALU_X:   state <= S_FETCH_A;
                S_BRANCH:  state <= S_FETCH_A;
                S_HALT:    state <= S_HALT;
                default:   state <= S_FETCH_A;
            endcase
        end
    end

    always_comb begin
        {ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR,
         ALU_ACC, ALU_add, ALU_sub, ALU_and, INC_PC, Addr_bus, CS, R_NW, halted} = '0;
        if (!reset) begin
            case (state)
                S_FETCH_A: {PC_bus, load_MAR, INC_PC, load_PC} = '1;
                S_FETCH_R: {CS, R_NW} = '1;
                S_FETCH_I: {MDR_bus, load_IR} = '1;
                S_DECODE: begin
                    {Addr_bus, load_MAR} = '1;
                    load_PC = op_jmp;
                end
                S_ST_M:    {ACC_bus, load_MDR} = '1;
                S_ST_W:    CS = 1'b1;
                S_EX_R:    {CS, R_NW} = '1;
                S_LD_A:    {MDR_bus, load_ACC} = '1;
                S_ALU_X: begin
                    {MDR_bus, ALU_ACC, load_ACC} = '1;
                    ALU_add = op_add;
                    ALU_sub = op_sub;
                    ALU_and = op_and;
                end
                S_BRANCH:  {MDR_bus, load_PC} = '1;
                S_HALT:    halted = 1'b1;
                default:   halted = op_nop && 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sequencer_wait.sv
// tb_sequencer_wait: self-checking bench for sequencer_wait (table vectors, random model run, corner sequences)
module tb_sequencer_wait;

    logic       clock = 1'b0;
    logic       reset, z_flag, mem_ready;
    logic [3:0] op;
    logic       ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR;
    logic       ALU_ACC, ALU_add, ALU_sub, ALU_and, INC_PC, Addr_bus, CS, R_NW, halted, bus_error;

    sequencer_wait dut (
        .clock(clock), .reset(reset), .z_flag(z_flag), .op(op), .mem_ready(mem_ready),
        .ACC_bus(ACC_bus), .load_ACC(load_ACC), .PC_bus(PC_bus), .load_PC(load_PC),
        .load_IR(load_IR), .load_MAR(load_MAR), .MDR_bus(MDR_bus), .load_MDR(load_MDR),
        .ALU_ACC(ALU_ACC), .ALU_add(ALU_add), .ALU_sub(ALU_sub), .ALU_and(ALU_and),
        .INC_PC(INC_PC), .Addr_bus(Addr_bus), .CS(CS), .R_NW(R_NW),
        .halted(halted), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    wire [16:0] outs = {ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR,
                        ALU_ACC, ALU_add, ALU_sub, ALU_and, INC_PC, Addr_bus, CS, R_NW, halted};

    localparam logic [16:0] O_ACC  = 17'h1 << 16, O_LACC = 17'h1 << 15, O_PC   = 17'h1 << 14;
    localparam logic [16:0] O_LPC  = 17'h1 << 13, O_LIR  = 17'h1 << 12, O_LMAR = 17'h1 << 11;
    localparam logic [16:0] O_MDR  = 17'h1 << 10, O_LMDR = 17'h1 << 9,  O_AACC = 17'h1 << 8;
    localparam logic [16:0] O_ADD  = 17'h1 << 7,  O_SUB  = 17'h1 << 6,  O_AND  = 17'h1 << 5;
    localparam logic [16:0] O_INC  = 17'h1 << 4,  O_ADDR = 17'h1 << 3,  O_CS   = 17'h1 << 2;
    localparam logic [16:0] O_RNW  = 17'h1 << 1,  O_HLT  = 17'h1;

    localparam logic [16:0] FA   = O_PC | O_LMAR | O_INC | O_LPC;
    localparam logic [16:0] RD   = O_CS | O_RNW;
    localparam logic [16:0] FI   = O_MDR | O_LIR;
    localparam logic [16:0] DE   = O_ADDR | O_LMAR;
    localparam logic [16:0] STM  = O_ACC | O_LMDR;
    localparam logic [16:0] STW  = O_CS;
    localparam logic [16:0] LDA  = O_MDR | O_LACC;
    localparam logic [16:0] ALUX = O_MDR | O_AACC | O_LACC;
    localparam logic [16:0] BR   = O_MDR | O_LPC;

    localparam int LOAD = 0, STORE = 1, ADD = 2, SUB = 3, BNE = 4, BEQ = 5;
    localparam int JMP = 6, AND = 7, NOP = 8, HALT = 15;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One microcycle of the reference flow: expected strobes, whether it is a
    // memory cycle, and whether its wait count comes from the fetch or the operand access.
    typedef struct {
        logic [16:0] o;
        bit          mem;
        bit          fetch;
    } phase_t;

    phase_t ph[$];

    function automatic bit long_op(int opc, bit z);
        return opc inside {LOAD, STORE, ADD, SUB, AND} || (opc == BNE && !z) || (opc == BEQ && z);
    endfunction

    function automatic void build(int opc, bit z);
        ph.delete();
        ph.push_back('{FA, 1'b0, 1'b0});
        ph.push_back('{RD, 1'b1, 1'b1});
        ph.push_back('{FI, 1'b0, 1'b0});
        ph.push_back('{(opc == JMP) ? (DE | O_LPC) : DE, 1'b0, 1'b0});
        if (opc == STORE) begin
            ph.push_back('{STM, 1'b0, 1'b0});
            ph.push_back('{STW, 1'b1, 1'b0});
        end else if (long_op(opc, z)) begin
            ph.push_back('{RD, 1'b1, 1'b0});
            if (opc == LOAD)
                ph.push_back('{LDA, 1'b0, 1'b0});
            else if (opc == BNE || opc == BEQ)
                ph.push_back('{BR, 1'b0, 1'b0});
            else
                ph.push_back('{ALUX | ((opc == ADD) ? O_ADD : (opc == SUB) ? O_SUB : O_AND), 1'b0, 1'b0});
        end else if (opc == HALT)
            ph.push_back('{O_HLT, 1'b0, 1'b0});
    endfunction

    // Runs one instruction starting at a falling edge with the sequencer in FETCH_A.
    // fw / ew = number of not-ready cycles inserted in the fetch / operand memory cycle.
    task automatic run(input int opc, input bit z, input int fw, input int ew,
                       output int cyc, output logic [16:0] last);
        int idx = 0;
        int left = -1;
        build(opc, z);
        op = opc[3:0];
        z_flag = z;
        cyc = 0;
        #1;
        while (idx < ph.size()) begin
            chk("outs", outs, ph[idx].o);
            chk("bus_error_clear", bus_error, 0);
            cyc++;
            last = outs;
            if (ph[idx].mem) begin
                if (left < 0) left = ph[idx].fetch ? fw : ew;
                mem_ready = (left == 0);
                if (left == 0) begin
                    idx++;
                    left = -1;
                end else
                    left--;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                idx++;
            end
            @(negedge clock);
        end
    endtask

    typedef struct {
        int          opc;
        bit          z;
        int          fw;
        int          ew;
        int          cyc;
        logic [16:0] last;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int          cyc;
        int          n;
        int          opc;
        bit          z;
        int          fw;
        int          ew;
        logic [16:0] last;

        tbl[0]  = '{LOAD,  1'b0, 0, 0, 6, LDA};
        tbl[1]  = '{LOAD,  1'b0, 0, 3, 9, LDA};
        tbl[2]  = '{STORE, 1'b0, 0, 1, 7, STW};
        tbl[3]  = '{ADD,   1'b1, 2, 0, 8, ALUX | O_ADD};
        tbl[4]  = '{AND,   1'b0, 0, 0, 6, ALUX | O_AND};
        tbl[5]  = '{SUB,   1'b0, 0, 0, 6, ALUX | O_SUB};
        tbl[6]  = '{JMP,   1'b0, 0, 0, 4, DE | O_LPC};
        tbl[7]  = '{BNE,   1'b1, 0, 0, 4, DE};
        tbl[8]  = '{BNE,   1'b0, 0, 0, 6, BR};
        tbl[9]  = '{BEQ,   1'b1, 0, 0, 6, BR};
        tbl[10] = '{BEQ,   1'b0, 1, 0, 5, DE};
        tbl[11] = '{NOP,   1'b0, 0, 0, 4, DE};
        tbl[12] = '{12,    1'b1, 0, 0, 4, DE};

        reset = 1'b1;
        z_flag = 1'b0;
        mem_ready = 1'b0;
        op = '0;
        #1;
        chk("reset_outs", outs, 0);
        chk("reset_bus_error", bus_error, 0);
        @(negedge clock);
        reset = 1'b0;

        foreach (tbl[i]) begin
            run(tbl[i].opc, tbl[i].z, tbl[i].fw, tbl[i].ew, cyc, last);
            chk("vec_cycles", cyc, tbl[i].cyc);
            chk("vec_last", last, tbl[i].last);
        end

        // Reset arriving while an operand read is stalled.
        op = LOAD[3:0];
        z_flag = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(negedge clock);
        mem_ready = 1'b0;
        @(negedge clock);
        chk("pre_reset_ex_r", outs, RD);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outs", outs, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_reset_fetch", outs, FA);

        // Randomised instruction stream against the reference flow.
        for (int k = 0; k < 40; k++) begin
            opc = int'($urandom_range(0, 14));
            z = 1'($urandom_range(0, 1));
            fw = int'($urandom_range(0, 3));
            ew = int'($urandom_range(0, 3));
            run(opc, z, fw, ew, cyc, last);
            chk("rand_latency", cyc, (long_op(opc, z) ? 6 : 4) + fw + (long_op(opc, z) ? ew : 0));
        end

        // HALT: stays halted with no strobes whatever the inputs do.
        run(HALT, 1'b0, 1, 0, cyc, last);
        chk("halt_cycles", cyc, 6);
        chk("halt_entry", last, O_HLT);
        for (int k = 0; k < 100; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            z_flag = 1'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 15));
            @(negedge clock);
            chk("halt_hold", outs, O_HLT);
        end
        reset = 1'b1;
        #1;
        chk("halt_reset", outs, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("halt_release", outs, FA);

`ifdef SEQ_MEM_TIMEOUT_EN
        // Store whose write never completes: 16 ST_W cycles, then HALT with bus_error.
        op = STORE[3:0];
        mem_ready = 1'b1;
        repeat (4) @(negedge clock);
        chk("to_st_m", outs, STM);
        mem_ready = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && !halted; k++) begin
            @(negedge clock);
            if (outs == STW) n++;
        end
        chk("to_st_w_cycles", n, 16);
        chk("to_halted", outs, O_HLT);
        chk("to_bus_error", bus_error, 1);
        for (int k = 0; k < 5; k++) begin
            mem_ready = 1'b1;
            @(negedge clock);
            chk("to_sticky", {halted, bus_error}, 2'b11);
        end
        reset = 1'b1;
        #1;
        chk("to_reset_err", bus_error, 0);
        @(negedge clock);
        reset = 1'b0;
        // Ready on the limit cycle completes the write with no error.
        mem_ready = 1'b1;
        repeat (4) @(negedge clock);
        mem_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            chk("lim_st_w", outs, STW);
            if (k == 16) mem_ready = 1'b1;
        end
        @(negedge clock);
        chk("lim_complete", outs, FA);
        chk("lim_no_error", bus_error, 0);
`else
        n = 0;
        op = STORE[3:0];
        mem_ready = 1'b1;
        repeat (4) @(negedge clock);
        mem_ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (outs == STW) n++;
        end
        chk("nowait_limit_st_w", n, 30);
        chk("nowait_bus_error", bus_error, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
